mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares the single physical memory port between the instruction-fetch requester (I) and the load/store requester (D) of the LC-3b multicycle core. It sits between the control/datapath memory signals (or the split I/D caches) and physical memory. It grants one requester at a time, muxes its command onto the physical port, and routes the response back. Arbitration is round-robin.

## Interface
- ADDR_WIDTH, 16, address width (lc3b_word)
- DATA_WIDTH, 16, data width (lc3b_word)
- BE_WIDTH, 2, byte-enable width (lc3b_mem_wmask)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_read, i_write  in  1 each  I requester commands
- i_address  in  ADDR_WIDTH  I address
- i_wdata  in  DATA_WIDTH  I write data
- i_byte_enable  in  BE_WIDTH  I byte enables
- i_resp  out  1  I transaction complete (one cycle)
- i_rdata  out  DATA_WIDTH  I read data, valid with i_resp
- d_read, d_write, d_address, d_wdata, d_byte_enable, d_resp, d_rdata: same as I set, for D
- pmem_read, pmem_write  out  1 each  physical memory commands
- pmem_address  out  ADDR_WIDTH
- pmem_wdata  out  DATA_WIDTH
- pmem_byte_enable  out  BE_WIDTH
- pmem_resp  in  1  physical memory done
- pmem_rdata  in  DATA_WIDTH
- busy  out  1  high in SERVE_I or SERVE_D

## Operation
- States: IDLE, SERVE_I, SERVE_D. Registered state plus one-bit last_grant (0 = I, 1 = D).
- Request: req_x = x_read | x_write. If both read and write are asserted, write wins and read is masked on pmem.
- IDLE: req_i only -> SERVE_I. req_d only -> SERVE_D. Both -> serve the port not equal to last_grant. Neither -> stay.
- SERVE_x:
  - pmem_* = x_* (combinational mux).
  - pmem_resp -> x_resp = 1 and x_rdata = pmem_rdata that cycle; last_grant <= x; next IDLE.
  - Otherwise, if req_x drops (abort) -> next IDLE, last_grant unchanged, no x_resp.
  - Otherwise stay.
- The non-granted port sees resp = 0 at all times. Its rdata is driven with pmem_rdata but is meaningless without resp.
- Requesters hold command, address, wdata and byte_enable stable until resp. The arbiter does not register them.
- In IDLE all pmem_* commands are 0. pmem_address, wdata and byte_enable are don't-care but driven from I for determinism.
- pmem_resp arriving in IDLE is ignored and routed nowhere.

## Timing
- Reset (rst_n low, any time, including mid-transaction): state = IDLE, last_grant = 1 (so I wins the first tie), all pmem_read/pmem_write/i_resp/d_resp/busy = 0 immediately (asynchronous).
- Grant latency: request sampled at edge N in IDLE; pmem command asserted in cycle N+1.
- Completion: x_resp is asserted in the same cycle as pmem_resp. The arbiter is back in IDLE the following cycle, and a new grant is effective one cycle after that.
- Minimum turnaround per transaction: 2 cycles arbiter overhead + memory latency.
- Back-to-back contention: I and D alternate strictly. Neither port waits more than one full transaction of the other.
- The requester must deassert or change its request in the cycle after resp. A request still asserted in IDLE is treated as a new request (this is LC-3b FSM behaviour: fetch2 -> fetch3).

## Test plan
- Reset then single I read at 0x0040, memory responds after 3 cycles with 0x1234 -> pmem_read high cycles 1-4, i_resp one cycle with i_rdata = 0x1234, d_resp never asserted.
- Simultaneous I read 0x0100 and D write 0x2000 data 0xBEEF BE = 2'b01 right after reset -> I served first, then D with pmem_wdata = 0xBEEF and pmem_byte_enable = 2'b01; IDLE cycle between them.
- Both ports continuously requesting for 6 transactions -> grant order I, D, I, D, I, D; busy low exactly one cycle between each.
- D asserts d_read and d_write together at 0x3000 -> pmem_write = 1, pmem_read = 0.
- D granted and drops d_read before pmem_resp -> IDLE next cycle, no d_resp, last_grant unchanged (pending I then served per prior last_grant).
- rst_n asserted low mid-SERVE_D while pmem_resp is pending -> pmem_write/pmem_read and busy go 0 immediately. A later pmem_resp in IDLE produces no i_resp or d_resp.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the LC-3b
// instruction-fetch (I) and load/store (D) requesters.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BE_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BE_WIDTH-1:0]   i_byte_enable,
    output logic                  i_resp,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [BE_WIDTH-1:0]   d_byte_enable,
    output logic                  d_resp,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    output logic [BE_WIDTH-1:0]   pmem_byte_enable,
    input  logic                  pmem_resp,
    input  logic [DATA_WIDTH-1:0] pmem_rdata,

    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;  // 0 = I served last, 1 = D served last
    logic   req_i, req_d;
    logic   serve_i, serve_d;

    assign req_i   = i_read | i_write;
    assign req_d   = d_read | d_write;
    assign serve_i = (state_q == StServeI);
    assign serve_d = (state_q == StServeD);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                // On a tie, grant the port that was not served last.
                if (req_i && (!req_d || last_grant_q)) begin
                    state_d = StServeI;
                end else if (req_d) begin
                    state_d = StServeD;
                end
            end
            StServeI: begin
                if (pmem_resp) begin
                    state_d      = StIdle;
                    last_grant_d = 1'b0;
                end else if (!req_i) begin
                    state_d = StIdle;
                end
            end
            StServeD: begin
                if (pmem_resp) begin
                    state_d      = StIdle;
                    last_grant_d = 1'b1;
                end else if (!req_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Write wins over read when a requester asserts both.
    always_comb begin
        pmem_write       = (serve_i & i_write) | (serve_d & d_write);
        pmem_read        = (serve_i & i_read & ~i_write) | (serve_d & d_read & ~d_write);
        pmem_address     = serve_d ? d_address     : i_address;
        pmem_wdata       = serve_d ? d_wdata       : i_wdata;
        pmem_byte_enable = serve_d ? d_byte_enable : i_byte_enable;
        i_resp           = serve_i & pmem_resp;
        d_resp           = serve_d & pmem_resp;
        i_rdata          = pmem_rdata;
        d_rdata          = pmem_rdata;
        busy             = serve_i | serve_d;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; physical memory responses are
// driven by hand at fixed cycles.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read, i_write, d_read, d_write;
    logic [15:0] i_address, i_wdata, d_address, d_wdata;
    logic [1:0]  i_byte_enable, d_byte_enable;
    logic        i_resp, d_resp;
    logic [15:0] i_rdata, d_rdata;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
    logic [1:0]  pmem_byte_enable;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_read           (i_read),
        .i_write          (i_write),
        .i_address        (i_address),
        .i_wdata          (i_wdata),
        .i_byte_enable    (i_byte_enable),
        .i_resp           (i_resp),
        .i_rdata          (i_rdata),
        .d_read           (d_read),
        .d_write          (d_write),
        .d_address        (d_address),
        .d_wdata          (d_wdata),
        .d_byte_enable    (d_byte_enable),
        .d_resp           (d_resp),
        .d_rdata          (d_rdata),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_resp        (pmem_resp),
        .pmem_rdata       (pmem_rdata),
        .busy             (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {i_read, i_write, d_read, d_write, pmem_resp} = '0;
        i_address = '0; i_wdata = '0; i_byte_enable = '0;
        d_address = '0; d_wdata = '0; d_byte_enable = '0;
        pmem_rdata = '0;
        settle();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd", {pmem_read, pmem_write}, 0);
        check_eq("rst_resp", {i_resp, d_resp}, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Single I read, memory answers in the 4th serve cycle.
        cyc();
        i_read = 1'b1; i_address = 16'h0040;
        settle();
        check_eq("t1_idle_rd", pmem_read, 0);
        cyc(); settle();
        check_eq("t1_c1_rd", pmem_read, 1);
        check_eq("t1_addr", pmem_address, 16'h0040);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_c1_iresp", i_resp, 0);
        cyc(); settle(); check_eq("t1_c2_rd", pmem_read, 1);
        cyc(); settle(); check_eq("t1_c3_rd", pmem_read, 1);
        cyc();
        pmem_resp = 1'b1; pmem_rdata = 16'h1234;
        settle();
        check_eq("t1_c4_rd", pmem_read, 1);
        check_eq("t1_iresp", i_resp, 1);
        check_eq("t1_irdata", i_rdata, 16'h1234);
        check_eq("t1_dresp", d_resp, 0);
        cyc();
        i_read = 1'b0; pmem_resp = 1'b0;
        settle();
        check_eq("t1_done_busy", busy, 0);
        check_eq("t1_done_rd", pmem_read, 0);
        check_eq("t1_done_iresp", i_resp, 0);

        // Simultaneous I read and D write right after reset: I first.
        rst_n = 1'b0; settle(); rst_n = 1'b1;
        cyc();
        i_read = 1'b1; i_address = 16'h0100;
        d_write = 1'b1; d_address = 16'h2000; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
        cyc(); settle();
        check_eq("t2_i_rd", pmem_read, 1);
        check_eq("t2_i_wr", pmem_write, 0);
        check_eq("t2_i_addr", pmem_address, 16'h0100);
        pmem_resp = 1'b1; pmem_rdata = 16'h5555;
        settle();
        check_eq("t2_iresp", i_resp, 1);
        check_eq("t2_dresp_masked", d_resp, 0);
        cyc();
        i_read = 1'b0; pmem_resp = 1'b0;
        settle();
        check_eq("t2_gap_busy", busy, 0);
        check_eq("t2_gap_wr", pmem_write, 0);
        cyc(); settle();
        check_eq("t2_d_wr", pmem_write, 1);
        check_eq("t2_d_rd", pmem_read, 0);
        check_eq("t2_d_addr", pmem_address, 16'h2000);
        check_eq("t2_d_wdata", pmem_wdata, 16'hBEEF);
        check_eq("t2_d_be", pmem_byte_enable, 2'b01);
        check_eq("t2_d_early", d_resp, 0);
        pmem_resp = 1'b1;
        settle();
        check_eq("t2_dresp", d_resp, 1);
        check_eq("t2_iresp_masked", i_resp, 0);
        cyc();
        d_write = 1'b0; pmem_resp = 1'b0;

        // Continuous contention: strict I, D, I, D, I, D alternation.
        i_read = 1'b1; i_address = 16'h1111;
        d_read = 1'b1; d_address = 16'h2222;
        for (int k = 0; k < 6; k++) begin
            cyc(); settle();
            check_eq($sformatf("t3_busy_%0d", k), busy, 1);
            check_eq($sformatf("t3_addr_%0d", k), pmem_address,
                     (k % 2 == 0) ? 16'h1111 : 16'h2222);
            pmem_resp = 1'b1; pmem_rdata = 16'(k);
            settle();
            check_eq($sformatf("t3_resp_%0d", k), {i_resp, d_resp},
                     (k % 2 == 0) ? 2'b10 : 2'b01);
            cyc();
            pmem_resp = 1'b0;
            settle();
            check_eq($sformatf("t3_gap_%0d", k), busy, 0);
        end
        i_read = 1'b0; d_read = 1'b0;

        // D with read and write together: write wins.
        cyc();
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h3000;
        cyc(); settle();
        check_eq("t4_wr", pmem_write, 1);
        check_eq("t4_rd", pmem_read, 0);
        check_eq("t4_addr", pmem_address, 16'h3000);
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;

        // I-only transaction so I is the last grant.
        i_read = 1'b1; i_address = 16'h0200;
        cyc(); settle();
        check_eq("t5_pre_addr", pmem_address, 16'h0200);
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0; i_read = 1'b0;

        // D abort leaves last grant at I, so a following tie goes to D.
        d_read = 1'b1; d_address = 16'h4000;
        cyc(); settle();
        check_eq("t5_d_granted", pmem_address, 16'h4000);
        d_read = 1'b0; i_read = 1'b1; i_address = 16'h0300;
        settle();
        check_eq("t5_abort_dresp", d_resp, 0);
        cyc(); settle();
        check_eq("t5_abort_idle", busy, 0);
        check_eq("t5_abort_rd", pmem_read, 0);
        d_read = 1'b1;
        cyc(); settle();
        check_eq("t5_tie_to_d", pmem_address, 16'h4000);
        pmem_resp = 1'b1;
        settle();
        check_eq("t5_tie_dresp", {i_resp, d_resp}, 2'b01);
        cyc();
        pmem_resp = 1'b0; d_read = 1'b0; i_read = 1'b0;

        // Asynchronous reset in the middle of a D write.
        d_write = 1'b1; d_address = 16'h5000;
        cyc(); settle();
        check_eq("t6_wr_before", pmem_write, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_wr", pmem_write, 0);
        check_eq("t6_rst_rd", pmem_read, 0);
        check_eq("t6_rst_busy", busy, 0);
        d_write = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        pmem_resp = 1'b1;
        settle();
        check_eq("t6_late_resp", {i_resp, d_resp}, 0);
        check_eq("t6_late_busy", busy, 0);
        cyc();
        pmem_resp = 1'b0;
        settle();
        check_eq("t6_still_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
